tlb_op_ctrl: RTL

Sequencer that executes TLB maintenance instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It sits between the EXE/MEM-stage instruction pipeline and the address-translation/TLB block. It drives that block's search, write, fill and invalidate request strobes and consumes its search-finish, index/found and read-port results. It returns CSR write-backs for TLBIDX, TLBEHI, TLBELO0, TLBELO1 and ASID, plus a completion pulse to the pipeline.

---
 rtl/tlb_op_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_op_ctrl
//
// Sequencer for the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL
// and INVTLB. It sits between the EXE/MEM pipeline and the translation/TLB
// block. It issues the search, write, fill and invalidate strobes, and it
// turns the TLB results into CSR write-backs and a one-cycle completion pulse.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   flush                 pipeline/exception/ertn flush; aborts any op in flight
//   op_valid/op_ready     op handshake; op_type 0..4 = SRCH/RD/WR/FILL/INV
//   inv_op/asid/vpn       INVTLB operands, latched when the op is accepted
//   csr_tlbidx            current TLBIDX value, merged into TLBIDX write-backs
//   tlbserch_en           search request, held until serch_tlb_finish
//   serch_tlb_finish,
//   tlbindex, tlbfound    search result from the TLB
//   r_*                   TLB read port (entry selected by csr_tlbidx index)
//   tlb_wen, tlb_fill_en  write / fill strobes; rand_index is the fill slot
//   tlbinv_en, tlbinv_*   invalidate strobe and its latched operands
//   *_we / *_wdata        CSR write-backs (TLBIDX, TLBEHI, TLBELO0/1, ASID)
//   op_done, op_err       completion pulse; op_err flags an illegal op
// -----------------------------------------------------------------------------
module tlb_op_ctrl #(
  parameter int TLBNUM = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_type,
  input  logic [4:0]         inv_op,
  input  logic [9:0]         inv_asid,
  input  logic [18:0]        inv_vpn,
  input  logic [31:0]        csr_tlbidx,
  output logic               tlbserch_en,
  input  logic               serch_tlb_finish,
  input  logic [$clog2(TLBNUM)-1:0] tlbindex,
  input  logic               tlbfound,
  input  logic [18:0]        r_vppn,
  input  logic [9:0]         r_asid,
  input  logic               r_g,
  input  logic [5:0]         r_ps,
  input  logic               r_e,
  input  logic               r_v0,
  input  logic               r_d0,
  input  logic [1:0]         r_mat0,
  input  logic [1:0]         r_plv0,
  input  logic [19:0]        r_ppn0,
  input  logic               r_v1,
  input  logic               r_d1,
  input  logic [1:0]         r_mat1,
  input  logic [1:0]         r_plv1,
  input  logic [19:0]        r_ppn1,
  output logic               tlb_wen,
  output logic               tlb_fill_en,
  output logic [$clog2(TLBNUM)-1:0] rand_index,
  output logic               tlbinv_en,
  output logic [4:0]         tlbinv_op,
  output logic [9:0]         tlbinv_asid,
  output logic [18:0]        tlbinv_vpn,
  output logic               tlbidx_we,
  output logic [31:0]        tlbidx_wdata,
  output logic               tlbehi_we,
  output logic [31:0]        tlbehi_wdata,
  output logic               tlbelo0_we,
  output logic [31:0]        tlbelo0_wdata,
  output logic               tlbelo1_we,
  output logic [31:0]        tlbelo1_wdata,
  output logic               asid_we,
  output logic [9:0]         asid_wdata,
  output logic               op_done,
  output logic               op_err
);

  localparam int IDXW = $clog2(TLBNUM);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  // Highest INVTLB op code the TLB understands; anything above is illegal.
  localparam logic [4:0] INV_OP_MAX = 5'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRCH = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  // Pack a TLBELO word: V[0] D[1] PLV[3:2] MAT[5:4] G[6] PPN[27:8], rest 0.
  function automatic logic [31:0] pack_elo(
    input logic        v,
    input logic        d,
    input logic [1:0]  plv,
    input logic [1:0]  mat,
    input logic        g,
    input logic [19:0] ppn
  );
    pack_elo = {4'b0000, ppn, 1'b0, g, mat, plv, d, v};
  endfunction

  // Replace NE[31] and PS[29:24] of a TLBIDX word, keeping every other bit.
  function automatic logic [31:0] merge_idx_ps(
    input logic [31:0] base,
    input logic        ne,
    input logic [5:0]  ps
  );
    merge_idx_ps = {ne, base[30], ps, base[23:0]};
  endfunction

  // TLBSRCH result: a hit clears NE and loads INDEX, a miss only sets NE.
  function automatic logic [31:0] merge_idx_srch(
    input logic [31:0]     base,
    input logic            found,
    input logic [IDXW-1:0] idx
  );
    if (found) begin
      merge_idx_srch = {1'b0, base[30:IDXW], idx};
    end else begin
      merge_idx_srch = {1'b1, base[30:0]};
    end
  endfunction

  state_t            state_r;
  state_t            state_nx_s;
  logic              accept_s;
  logic              op_ready_s;
  logic [2:0]        op_type_r;
  logic [4:0]        inv_op_r;
  logic [9:0]        inv_asid_r;
  logic [18:0]       inv_vpn_r;
  logic [IDXW-1:0]   rand_cnt_r;
  logic [IDXW-1:0]   rand_index_r;

  logic              tlbserch_en_s;
  logic              tlb_wen_s;
  logic              tlb_fill_en_s;
  logic              tlbinv_en_s;
  logic              tlbidx_we_s;
  logic [31:0]       tlbidx_wdata_s;
  logic              tlbehi_we_s;
  logic [31:0]       tlbehi_wdata_s;
  logic              tlbelo0_we_s;
  logic [31:0]       tlbelo0_wdata_s;
  logic              tlbelo1_we_s;
  logic [31:0]       tlbelo1_wdata_s;
  logic              asid_we_s;
  logic [9:0]        asid_wdata_s;
  logic              op_done_s;
  logic              op_err_s;

  // NE is always regenerated, so the incoming NE bit never reaches an output.
  logic              unused_s;
  assign unused_s = csr_tlbidx[31];

  assign op_ready_s = (state_r == ST_IDLE) & ~flush;
  assign accept_s   = op_valid & op_ready_s;

  // State register; reset lands in IDLE, dropping any in-flight strobe at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Capture the op and its INVTLB operands on accept; FILL also snapshots the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_type_r    <= 3'd0;
      inv_op_r     <= 5'd0;
      inv_asid_r   <= 10'd0;
      inv_vpn_r    <= 19'd0;
      rand_index_r <= '0;
    end else if (accept_s) begin
      op_type_r  <= op_type;
      inv_op_r   <= inv_op;
      inv_asid_r <= inv_asid;
      inv_vpn_r  <= inv_vpn;
      if (op_type == OP_FILL) begin
        rand_index_r <= rand_cnt_r;
      end
    end
  end

  // Free-running fill-slot counter; wraps naturally at TLBNUM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rand_cnt_r <= '0;
    end else begin
      rand_cnt_r <= rand_cnt_r + IDXW'(1);
    end
  end

  // Next-state logic; flush returns to IDLE from any state.
  always_comb begin
    state_nx_s = state_r;
    if (flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nx_s = (op_type == OP_SRCH) ? ST_SRCH : ST_EXEC;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_SRCH: begin
          if (serch_tlb_finish) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_SRCH;
          end
        end
        ST_EXEC: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Strobes and write-backs; a flush cycle suppresses every side effect.
  always_comb begin
    tlbserch_en_s   = 1'b0;
    tlb_wen_s       = 1'b0;
    tlb_fill_en_s   = 1'b0;
    tlbinv_en_s     = 1'b0;
    tlbidx_we_s     = 1'b0;
    tlbidx_wdata_s  = 32'd0;
    tlbehi_we_s     = 1'b0;
    tlbehi_wdata_s  = 32'd0;
    tlbelo0_we_s    = 1'b0;
    tlbelo0_wdata_s = 32'd0;
    tlbelo1_we_s    = 1'b0;
    tlbelo1_wdata_s = 32'd0;
    asid_we_s       = 1'b0;
    asid_wdata_s    = 10'd0;
    op_done_s       = 1'b0;
    op_err_s        = 1'b0;
    if (flush) begin
      op_done_s = 1'b0;
    end else begin
      case (state_r)
        ST_SRCH: begin
          // Request stays up through the finish cycle itself.
          tlbserch_en_s = 1'b1;
          if (serch_tlb_finish) begin
            tlbidx_we_s    = 1'b1;
            tlbidx_wdata_s = merge_idx_srch(csr_tlbidx, tlbfound, tlbindex);
            op_done_s      = 1'b1;
          end else begin
            op_done_s = 1'b0;
          end
        end
        ST_EXEC: begin
          op_done_s = 1'b1;
          case (op_type_r)
            OP_RD: begin
              tlbidx_we_s  = 1'b1;
              tlbehi_we_s  = 1'b1;
              tlbelo0_we_s = 1'b1;
              tlbelo1_we_s = 1'b1;
              asid_we_s    = 1'b1;
              if (r_e) begin
                tlbidx_wdata_s  = merge_idx_ps(csr_tlbidx, 1'b0, r_ps);
                tlbehi_wdata_s  = {r_vppn, 13'd0};
                tlbelo0_wdata_s = pack_elo(r_v0, r_d0, r_plv0, r_mat0, r_g, r_ppn0);
                tlbelo1_wdata_s = pack_elo(r_v1, r_d1, r_plv1, r_mat1, r_g, r_ppn1);
                asid_wdata_s    = r_asid;
              end else begin
                // Empty entry: report NE and clear the rest of the entry image.
                tlbidx_wdata_s = merge_idx_ps(csr_tlbidx, 1'b1, 6'd0);
              end
            end
            OP_WR:   tlb_wen_s     = 1'b1;
            OP_FILL: tlb_fill_en_s = 1'b1;
            OP_INV: begin
              if (inv_op_r <= INV_OP_MAX) begin
                tlbinv_en_s = 1'b1;
              end else begin
                op_err_s = 1'b1;
              end
            end
            default: op_err_s = 1'b1;
          endcase
        end
        default: op_done_s = 1'b0;
      endcase
    end
  end

  assign op_ready      = op_ready_s;
  assign tlbserch_en   = tlbserch_en_s;
  assign tlb_wen       = tlb_wen_s;
  assign tlb_fill_en   = tlb_fill_en_s;
  assign rand_index    = rand_index_r;
  assign tlbinv_en     = tlbinv_en_s;
  assign tlbinv_op     = inv_op_r;
  assign tlbinv_asid   = inv_asid_r;
  assign tlbinv_vpn    = inv_vpn_r;
  assign tlbidx_we     = tlbidx_we_s;
  assign tlbidx_wdata  = tlbidx_wdata_s;
  assign tlbehi_we     = tlbehi_we_s;
  assign tlbehi_wdata  = tlbehi_wdata_s;
  assign tlbelo0_we    = tlbelo0_we_s;
  assign tlbelo0_wdata = tlbelo0_wdata_s;
  assign tlbelo1_we    = tlbelo1_we_s;
  assign tlbelo1_wdata = tlbelo1_wdata_s;
  assign asid_we       = asid_we_s;
  assign asid_wdata    = asid_wdata_s;
  assign op_done       = op_done_s;
  assign op_err        = op_err_s;

endmodule
